hockey_menu_ctrl: RTL

Sequencer for the E-Hockey top-level screens. It debounces the player buttons and steps the menu's 3-bit `mode` selection (win target = mode+1 goals). It runs the MENU → COUNTDOWN → PLAY → GAMEOVER state machine, keeps both players' scores, and tells the VGA mux which screen to draw. It sits between the board buttons and game-logic goal pulses on one side, and the menu renderer, play-field logic and pixel mux on the other.

---
 rtl/hockey_menu_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/hockey_menu_ctrl.sv
// E-Hockey screen sequencer: button debounce, menu mode select, MENU/COUNTDOWN/PLAY/GAMEOVER FSM, scoring.
// Build option: define HOCKEY_MODE_WRAP_EN to make mode wrap (7->0, 0->7) instead of saturating.
`timescale 1ns/1ps

module hockey_btn_db #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1, sync2;
  logic          db, db_d;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      press <= db & ~db_d;
      // The counter only advances while the synced level disagrees with the accepted one.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module hockey_menu_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int CD_FRAMES = 180,
  parameter int GO_FRAMES = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       frame_tick,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic [2:0] mode,
  output logic [1:0] screen,
  output logic       game_en,
  output logic       game_clr,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [1:0] winner,
  output logic [1:0] cd_digit
);

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_CD    = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int F_MAX = (CD_FRAMES > GO_FRAMES) ? CD_FRAMES : GO_FRAMES;
  localparam int FW    = $clog2(F_MAX + 1);
  localparam logic [FW-1:0] CD_LAST = FW'(CD_FRAMES - 1);
  localparam logic [FW-1:0] GO_LAST = FW'(GO_FRAMES - 1);
  localparam logic [FW-1:0] CD_T1   = FW'(CD_FRAMES / 3);
  localparam logic [FW-1:0] CD_T2   = FW'((2 * CD_FRAMES) / 3);

  logic ev_up, ev_down, ev_sel;

  hockey_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .press(ev_up)
  );
  hockey_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .raw(btn_down), .press(ev_down)
  );
  hockey_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .raw(btn_sel), .press(ev_sel)
  );

  state_t        state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [2:0]    mode_n, sc1_n, sc2_n;
  logic [1:0]    win_n, digit_n;
  logic          clr_n, en_n;

  // Scores are compared in 4 bits because the win target reaches 8 when mode is 7.
  logic [3:0] tgt, n1, n2;
  logic       hit1, hit2;

  assign tgt  = {1'b0, mode} + 4'd1;
  assign n1   = {1'b0, score_p1} + {3'b000, goal_p1};
  assign n2   = {1'b0, score_p2} + {3'b000, goal_p2};
  assign hit1 = goal_p1 && (n1 == tgt);
  assign hit2 = goal_p2 && (n2 == tgt);

  assign screen = state;

  // NOTE: every variable below gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    mode_n  = mode;
    sc1_n   = score_p1;
    sc2_n   = score_p2;
    win_n   = winner;
    clr_n   = 1'b0;

    unique case (state)
      ST_MENU: begin
        if (ev_sel) begin
          sc1_n   = 3'd0;
          sc2_n   = 3'd0;
          win_n   = 2'd0;
          clr_n   = 1'b1;
          state_n = ST_CD;
          fcnt_n  = '0;
        end else if (ev_up && !ev_down) begin
`ifdef HOCKEY_MODE_WRAP_EN
          mode_n = mode + 3'd1;
`else
          if (mode != 3'd7) mode_n = mode + 3'd1;
`endif
        end else if (ev_down && !ev_up) begin
`ifdef HOCKEY_MODE_WRAP_EN
          mode_n = mode - 3'd1;
`else
          if (mode != 3'd0) mode_n = mode - 3'd1;
`endif
        end
      end

      ST_CD: begin
        if (frame_tick) begin
          if (fcnt == CD_LAST) begin
            state_n = ST_PLAY;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (goal_p1 && score_p1 != 3'd7) sc1_n = score_p1 + 3'd1;
        if (goal_p2 && score_p2 != 3'd7) sc2_n = score_p2 + 3'd1;
        if (hit1 || hit2) begin
          win_n   = {hit2, hit1};
          state_n = ST_OVER;
          fcnt_n  = '0;
        end else if (goal_p1 || goal_p2) begin
          clr_n = 1'b1;
        end
      end

      ST_OVER: begin
        if (ev_sel) begin
          state_n = ST_MENU;
          fcnt_n  = '0;
        end else if (frame_tick) begin
          if (fcnt == GO_LAST) begin
            state_n = ST_MENU;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end

      default: state_n = ST_MENU;
    endcase

    en_n = (state_n == ST_PLAY);

    if (state_n != ST_CD)  digit_n = 2'd0;
    else if (fcnt_n < CD_T1) digit_n = 2'd3;
    else if (fcnt_n < CD_T2) digit_n = 2'd2;
    else                     digit_n = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_MENU;
      fcnt     <= '0;
      mode     <= 3'd0;
      score_p1 <= 3'd0;
      score_p2 <= 3'd0;
      winner   <= 2'd0;
      game_clr <= 1'b0;
      game_en  <= 1'b0;
      cd_digit <= 2'd0;
    end else begin
      state    <= state_n;
      fcnt     <= fcnt_n;
      mode     <= mode_n;
      score_p1 <= sc1_n;
      score_p2 <= sc2_n;
      winner   <= win_n;
      game_clr <= clr_n;
      game_en  <= en_n;
      cd_digit <= digit_n;
    end
  end

endmodule
